// File: rtl/cmem_burst_ctl.sv
// Line-to-beat burst controller: turns each cache line read/write into N BEAT_W-wide
// requests on a valid/ready bus and gathers in-order read responses back into a line.
module cmem_burst_ctl #(
  parameter int LINE_W = 512,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_rd,
  input  logic              c_wr,
  input  logic [LINE_W-1:0] c_wdata,
  output logic [LINE_W-1:0] c_rdata,
  output logic              c_dv,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_valid,
  output logic              m_we,
  output logic [BEAT_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [BEAT_W-1:0] m_rdata
);

  localparam int N  = LINE_W / BEAT_W;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0]     LAST       = CW'(N - 1);
  localparam logic [CW-1:0]     NBEATS     = CW'(N);
  localparam logic [CW-1:0]     ONE        = CW'(1);
  localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(LINE_W / 8 - 1);
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BEAT_W / 8);

  typedef enum logic [2:0] {IDLE, WR, RD, DONE, DROP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_addr;
  logic [LINE_W-1:0] wline;
  logic [CW-1:0]     issue_cnt, resp_cnt;
  logic              req_fire, resp_take;

  always_comb begin
    state_nxt = state;
    m_valid   = 1'b0;
    m_we      = 1'b0;
    c_dv      = 1'b0;
    case (state)
      IDLE: begin
        if (c_wr)      state_nxt = WR;
        else if (c_rd) state_nxt = RD;
      end
      WR: begin
        m_valid = 1'b1;
        m_we    = 1'b1;
        if (m_ready && issue_cnt == LAST) state_nxt = DONE;
      end
      RD: begin
        // Requests and responses overlap; finishing is governed only by the last response.
        m_valid = (issue_cnt < NBEATS);
        if (m_rvalid && resp_cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        c_dv      = 1'b1;
        state_nxt = DROP;
      end
      DROP: begin
        if (!c_rd && !c_wr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_fire  = m_valid && m_ready;
  assign resp_take = (state == RD) && m_rvalid;
  assign m_addr    = m_valid ? base_addr + ADDR_W'(issue_cnt) * BEAT_BYTES : '0;
  assign m_wdata   = m_we ? wline[int'(issue_cnt[CW-2:0]) * BEAT_W +: BEAT_W] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_addr <= '0;
      wline     <= '0;
      issue_cnt <= '0;
      resp_cnt  <= '0;
      c_rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        issue_cnt <= '0;
        resp_cnt  <= '0;
        if (c_wr || c_rd) base_addr <= c_addr & ~LINE_MASK;
        if (c_wr)         wline     <= c_wdata;
      end
      if (req_fire) issue_cnt <= issue_cnt + ONE;
      // c_rdata is never cleared between reads; it holds until the next read's first response.
      if (resp_take) begin
        c_rdata[int'(resp_cnt[CW-2:0]) * BEAT_W +: BEAT_W] <= m_rdata;
        resp_cnt <= resp_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_cmem_burst_ctl.sv
// Self-checking bench for cmem_burst_ctl: a behavioural memory bus model logs accepted
// beats and returns in-order read data; each scenario compares against line-level expectations.
module tb_cmem_burst_ctl;

  localparam int LINE_W = 512;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 64;
  localparam int N      = LINE_W / BEAT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] c_addr = '0;
  logic              c_rd = 1'b0;
  logic              c_wr = 1'b0;
  logic [LINE_W-1:0] c_wdata = '0;
  logic [LINE_W-1:0] c_rdata;
  logic              c_dv;
  logic [ADDR_W-1:0] m_addr;
  logic              m_valid;
  logic              m_we;
  logic [BEAT_W-1:0] m_wdata;
  logic              m_ready = 1'b0;
  logic              m_rvalid = 1'b0;
  logic [BEAT_W-1:0] m_rdata = '0;

  always #5 clk = ~clk;

  cmem_burst_ctl #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_addr(c_addr), .c_rd(c_rd), .c_wr(c_wr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_dv(c_dv),
    .m_addr(m_addr), .m_valid(m_valid), .m_we(m_we), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic              log_we[$];
  logic [BEAT_W-1:0] log_wdata[$];
  logic [BEAT_W-1:0] resp_src[$];
  logic [BEAT_W-1:0] resp_q[$];
  int                cyc, dv_count, dv_cyc, last_acc_cyc, stall_err, resp_driven, ready_mode;
  bit                jitter, prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [BEAT_W-1:0] prev_wdata;

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] a, input int i);
    logic [ADDR_W-1:0] line_bytes;
    line_bytes = ADDR_W'(LINE_W / 8);
    return (a - (a % line_bytes)) + ADDR_W'(i * (BEAT_W / 8));
  endfunction

  function automatic logic [BEAT_W-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  task automatic reset_log();
    log_addr.delete(); log_we.delete(); log_wdata.delete();
    resp_src.delete(); resp_q.delete();
    cyc = 0; dv_count = 0; dv_cyc = -1; last_acc_cyc = -1;
    stall_err = 0; resp_driven = 0; prev_stall = 0;
  endtask

  // One bus cycle: sample outputs, drive ready/response, log the handshake due at the next edge.
  task automatic bus_step();
    @(negedge clk);
    cyc++;
    if (c_dv === 1'b1) begin
      dv_count++;
      dv_cyc = cyc;
    end
    if (prev_stall && (m_valid !== 1'b1 || m_addr !== prev_addr || m_wdata !== prev_wdata))
      stall_err++;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 2 == 1);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    if (resp_q.size() != 0 && (!jitter || $urandom_range(0, 3) != 0)) begin
      m_rvalid = 1'b1;
      m_rdata  = resp_q.pop_front();
      resp_driven++;
    end else begin
      m_rvalid = 1'b0;
      m_rdata  = rand_beat();
    end
    if (m_valid === 1'b1 && m_ready) begin
      log_addr.push_back(m_addr);
      log_we.push_back(m_we);
      log_wdata.push_back(m_wdata);
      last_acc_cyc = cyc;
      if (m_we === 1'b0) resp_q.push_back(resp_src.size() != 0 ? resp_src.pop_front() : '0);
    end
    prev_stall = (m_valid === 1'b1) && !m_ready;
    prev_addr  = m_addr;
    prev_wdata = m_wdata;
  endtask

  task automatic run_txn(input bit rd, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wline, input int hold);
    @(negedge clk);
    c_rd = rd; c_wr = wr; c_addr = addr; c_wdata = wline; m_rvalid = 1'b0;
    for (int k = 0; k < 300 && dv_count == 0; k++) bus_step();
    if (dv_count == 0) $display("[TB] FAIL txn_timeout: no c_dv after 300 cycles, required one");
    for (int k = 0; k < hold; k++) bus_step();
    c_rd = 1'b0; c_wr = 1'b0;
    repeat (3) bus_step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; c_rd = 1'b1; c_wr = 1'b0; c_addr = 64'h2000_0010;
    m_ready = 1'b1; m_rvalid = 1'b1; m_rdata = '1;
    repeat (3) @(negedge clk);
    tests++; if ({c_dv, m_valid, m_we} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_ctrl: {c_dv,m_valid,m_we}=%b required 000", {c_dv, m_valid, m_we});
    end
    tests++; if (c_rdata !== '0) begin
      fails++; $display("[TB] FAIL reset_rdata: c_rdata=%h required 0", c_rdata);
    end
    tests++; if (m_addr !== '0 || m_wdata !== '0) begin
      fails++; $display("[TB] FAIL reset_bus: m_addr=%h m_wdata=%h required 0", m_addr, m_wdata);
    end
    reset_log(); ready_mode = 0; jitter = 0;
    for (int i = 0; i < N; i++) resp_src.push_back(rand_beat());
    m_rvalid = 1'b0;
    rst_n = 1'b1;
    bus_step();
    tests++; if (m_valid !== 1'b1 || m_addr !== 64'h2000_0000) begin
      fails++; $display("[TB] FAIL reset_release_start: m_valid=%b m_addr=%h required 1 / 20000000", m_valid, m_addr);
    end
    for (int k = 0; k < 100 && dv_count == 0; k++) bus_step();
    c_rd = 1'b0;
    repeat (3) bus_step();
    tests++; if (dv_count !== 1 || log_addr.size() !== N) begin
      fails++; $display("[TB] FAIL reset_release_burst: dv=%0d beats=%0d required 1 / %0d", dv_count, log_addr.size(), N);
    end
  endtask

  task automatic test_line_read();
    logic [LINE_W-1:0] exp_line;
    reset_log(); ready_mode = 0; jitter = 0;
    for (int i = 0; i < N; i++) begin
      resp_src.push_back(BEAT_W'((i + 1) * 'h11));
      exp_line[i*BEAT_W +: BEAT_W] = BEAT_W'((i + 1) * 'h11);
    end
    run_txn(1'b1, 1'b0, 64'h1000_0047, '0, 0);
    tests++; if (log_addr.size() !== N) begin
      fails++; $display("[TB] FAIL read_beats: got %0d required %0d", log_addr.size(), N);
    end
    for (int i = 0; i < N && i < log_addr.size(); i++) begin
      tests++; if (log_addr[i] !== 64'h1000_0040 + ADDR_W'(i * 8) || log_we[i] !== 1'b0) begin
        fails++; $display("[TB] FAIL read_req[%0d]: addr=%h we=%b required %h we=0", i, log_addr[i], log_we[i], 64'h1000_0040 + ADDR_W'(i * 8));
      end
    end
    tests++; if (c_rdata !== exp_line) begin
      fails++; $display("[TB] FAIL read_line: got %h required %h", c_rdata, exp_line);
    end
    tests++; if (dv_count !== 1 || dv_cyc !== N + 2) begin
      fails++; $display("[TB] FAIL read_dv: count=%0d cycle=%0d required 1 at %0d", dv_count, dv_cyc, N + 2);
    end
  endtask

  task automatic test_write_backpressure();
    logic [LINE_W-1:0] line;
    reset_log(); ready_mode = 1; jitter = 0;
    for (int i = 0; i < N; i++) line[i*BEAT_W +: BEAT_W] = BEAT_W'('hA0 + i);
    run_txn(1'b0, 1'b1, 64'h2000_0123, line, 0);
    tests++; if (log_addr.size() !== N) begin
      fails++; $display("[TB] FAIL write_beats: got %0d required %0d", log_addr.size(), N);
    end
    for (int i = 0; i < N && i < log_addr.size(); i++) begin
      tests++; if (log_addr[i] !== exp_addr(64'h2000_0123, i) || log_we[i] !== 1'b1 ||
                   log_wdata[i] !== BEAT_W'('hA0 + i)) begin
        fails++; $display("[TB] FAIL write_beat[%0d]: addr=%h we=%b data=%h required %h 1 %h", i, log_addr[i], log_we[i], log_wdata[i], exp_addr(64'h2000_0123, i), BEAT_W'('hA0 + i));
      end
    end
    tests++; if (stall_err !== 0) begin
      fails++; $display("[TB] FAIL write_stall_hold: %0d unstable stalls, required 0", stall_err);
    end
    tests++; if (dv_count !== 1 || dv_cyc !== last_acc_cyc + 1) begin
      fails++; $display("[TB] FAIL write_dv: count=%0d cycle=%0d required 1 at %0d", dv_count, dv_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_rd_wr_conflict();
    logic [LINE_W-1:0] line;
    logic [ADDR_W-1:0] addr;
    int                bad;
    reset_log(); ready_mode = 0; jitter = 0;
    for (int i = 0; i < N; i++) line[i*BEAT_W +: BEAT_W] = rand_beat();
    addr = {$urandom, $urandom};
    run_txn(1'b1, 1'b1, addr, line, 0);
    bad = 0;
    for (int i = 0; i < log_addr.size(); i++)
      if (log_we[i] !== 1'b1 || log_addr[i] !== exp_addr(addr, i) || log_wdata[i] !== line[i*BEAT_W +: BEAT_W]) bad++;
    tests++; if (log_addr.size() !== N || bad !== 0) begin
      fails++; $display("[TB] FAIL conflict_write_only: beats=%0d bad=%0d required %0d / 0", log_addr.size(), bad, N);
    end
    tests++; if (dv_count !== 1 || dv_cyc !== N + 1) begin
      fails++; $display("[TB] FAIL conflict_dv: count=%0d cycle=%0d required 1 at %0d", dv_count, dv_cyc, N + 1);
    end
  endtask

  task automatic test_held_request();
    logic [LINE_W-1:0] exp_line;
    reset_log(); ready_mode = 0; jitter = 0;
    for (int i = 0; i < N; i++) resp_src.push_back(rand_beat());
    run_txn(1'b1, 1'b0, 64'h3000_0000, '0, 5);
    tests++; if (log_addr.size() !== N || dv_count !== 1) begin
      fails++; $display("[TB] FAIL held_no_retrigger: beats=%0d dv=%0d required %0d / 1", log_addr.size(), dv_count, N);
    end
    reset_log();
    for (int i = 0; i < N; i++) begin
      exp_line[i*BEAT_W +: BEAT_W] = rand_beat();
      resp_src.push_back(exp_line[i*BEAT_W +: BEAT_W]);
    end
    run_txn(1'b1, 1'b0, 64'h3000_0080, '0, 0);
    tests++; if (log_addr.size() !== N || dv_count !== 1 || log_addr[0] !== 64'h3000_0080) begin
      fails++; $display("[TB] FAIL held_reassert: beats=%0d dv=%0d required %0d / 1 from 30000080", log_addr.size(), dv_count, N);
    end
    tests++; if (c_rdata !== exp_line) begin
      fails++; $display("[TB] FAIL held_reassert_line: got %h required %h", c_rdata, exp_line);
    end
  endtask

  task automatic test_mid_reset();
    logic [LINE_W-1:0] exp_line;
    logic [ADDR_W-1:0] addr;
    int                seen_dv;
    reset_log(); ready_mode = 0; jitter = 0;
    for (int i = 0; i < N; i++) resp_src.push_back(rand_beat());
    @(negedge clk);
    c_rd = 1'b1; c_addr = 64'h4000_0000;
    for (int k = 0; k < 100 && resp_driven < 3; k++) bus_step();
    tests++; if (resp_driven !== 3) begin
      fails++; $display("[TB] FAIL midreset_setup: responses=%0d required 3", resp_driven);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0; c_rd = 1'b0; m_rvalid = 1'b0; m_ready = 1'b0;
    #1;
    tests++; if (c_dv !== 1'b0 || m_valid !== 1'b0 || c_rdata !== '0) begin
      fails++; $display("[TB] FAIL midreset_clear: c_dv=%b m_valid=%b c_rdata=%h required 0 0 0", c_dv, m_valid, c_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_dv = 0;
    for (int s = 0; s < 2; s++) begin
      m_rvalid = 1'b1; m_rdata = rand_beat();
      @(negedge clk);
      if (c_dv !== 1'b0) seen_dv++;
    end
    m_rvalid = 1'b0;
    @(negedge clk);
    tests++; if (seen_dv !== 0 || c_dv !== 1'b0 || c_rdata !== '0) begin
      fails++; $display("[TB] FAIL midreset_stray: dv_pulses=%0d c_rdata=%h required 0 / 0", seen_dv, c_rdata);
    end
    reset_log();
    addr = {$urandom, $urandom};
    for (int i = 0; i < N; i++) begin
      exp_line[i*BEAT_W +: BEAT_W] = rand_beat();
      resp_src.push_back(exp_line[i*BEAT_W +: BEAT_W]);
    end
    run_txn(1'b1, 1'b0, addr, '0, 0);
    tests++; if (c_rdata !== exp_line || dv_count !== 1 || log_addr.size() !== N) begin
      fails++; $display("[TB] FAIL midreset_next_read: line=%h dv=%0d beats=%0d required %h 1 %0d", c_rdata, dv_count, log_addr.size(), exp_line, N);
    end
  endtask

  task automatic test_random();
    logic [LINE_W-1:0] line, exp_line;
    logic [ADDR_W-1:0] addr;
    int                kind, bad;
    bit                is_wr;
    for (int it = 0; it < 8; it++) begin
      reset_log(); ready_mode = 2; jitter = 1;
      kind  = $urandom_range(0, 2);
      is_wr = (kind != 0);
      addr  = {$urandom, $urandom};
      for (int i = 0; i < N; i++) begin
        line[i*BEAT_W +: BEAT_W]     = rand_beat();
        exp_line[i*BEAT_W +: BEAT_W] = rand_beat();
        resp_src.push_back(exp_line[i*BEAT_W +: BEAT_W]);
      end
      run_txn(kind != 1, kind != 0, addr, line, $urandom_range(0, 2));
      bad = 0;
      for (int i = 0; i < log_addr.size(); i++) begin
        if (log_addr[i] !== exp_addr(addr, i) || log_we[i] !== is_wr) bad++;
        if (is_wr && log_wdata[i] !== line[i*BEAT_W +: BEAT_W]) bad++;
      end
      tests++; if (log_addr.size() !== N || bad !== 0 || stall_err !== 0) begin
        fails++; $display("[TB] FAIL random_beats[%0d]: beats=%0d bad=%0d stalls=%0d required %0d 0 0", it, log_addr.size(), bad, stall_err, N);
      end
      tests++; if (dv_count !== 1 || (!is_wr && c_rdata !== exp_line)) begin
        fails++; $display("[TB] FAIL random_done[%0d]: dv=%0d line=%h required 1 / %h", it, dv_count, c_rdata, exp_line);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_read();
    test_write_backpressure();
    test_rd_wr_conflict();
    test_held_request();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
